// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: single outstanding read, one-entry hold register, flush redirect.
// Optional FETCH_TIMEOUT_EN adds a saturating no-ack counter driving a sticky fetch_err.
module fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_next,
    output logic        pc_write,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic        flush,
    input  logic [31:0] flush_target,
    output logic        fetch_err
);

    typedef enum logic [1:0] {IDLE, REQ, DRAIN, HOLD} state_t;

    state_t      state, state_n;
    logic        mem_req_n;
    logic [31:0] mem_addr_n;
    logic        inst_valid_n;
    logic [31:0] inst_out_n;
    logic [31:0] inst_pc_n;
    logic [31:0] redir, redir_n;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

    always_comb begin
        state_n      = state;
        mem_addr_n   = mem_addr;
        inst_valid_n = inst_valid;
        inst_out_n   = inst_out;
        inst_pc_n    = inst_pc;
        redir_n      = redir;
        pc_write     = 1'b0;
        pc_next      = pc_plus4(inst_pc);

        case (state)
            IDLE: begin
                state_n    = REQ;
                mem_addr_n = pc_in;
            end
            REQ: begin
                if (flush) begin
                    pc_write = 1'b1;
                    pc_next  = flush_target;
                    if (mem_ack) begin
                        mem_addr_n = flush_target;
                    end else begin
                        // Request cannot be withdrawn: wait out the stale ack in DRAIN.
                        state_n = DRAIN;
                        redir_n = flush_target;
                    end
                end else if (mem_ack) begin
                    inst_out_n   = mem_rdata;
                    inst_pc_n    = mem_addr;
                    inst_valid_n = 1'b1;
                    state_n      = HOLD;
                end
            end
            DRAIN: begin
                if (flush) begin
                    pc_write = 1'b1;
                    pc_next  = flush_target;
                    redir_n  = flush_target;
                end
                if (mem_ack) begin
                    state_n    = REQ;
                    mem_addr_n = flush ? flush_target : redir;
                end
            end
            HOLD: begin
                if (flush) begin
                    pc_write     = 1'b1;
                    pc_next      = flush_target;
                    inst_valid_n = 1'b0;
                    mem_addr_n   = flush_target;
                    state_n      = REQ;
                end else if (inst_ready) begin
                    pc_write     = 1'b1;
                    mem_addr_n   = pc_plus4(inst_pc);
                    inst_valid_n = 1'b0;
                    state_n      = REQ;
                end
            end
            default: state_n = IDLE;
        endcase

        if (rst) begin
            pc_write = 1'b0;
        end

        mem_req_n = (state_n == REQ) || (state_n == DRAIN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            mem_req    <= 1'b0;
            mem_addr   <= 32'd0;
            inst_valid <= 1'b0;
            inst_out   <= 32'd0;
            inst_pc    <= 32'd0;
            redir      <= 32'd0;
        end else begin
            state      <= state_n;
            mem_req    <= mem_req_n;
            mem_addr   <= mem_addr_n;
            inst_valid <= inst_valid_n;
            inst_out   <= inst_out_n;
            inst_pc    <= inst_pc_n;
            redir      <= redir_n;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    logic [7:0] tcnt, tcnt_n;
    logic       fetch_err_n;

    always_comb begin
        tcnt_n = 8'd0;
        if (((state == REQ) || (state == DRAIN)) && !mem_ack) begin
            tcnt_n = (tcnt == 8'hFF) ? tcnt : tcnt + 8'd1;
        end
        fetch_err_n = fetch_err || (tcnt_n == 8'hFF);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tcnt      <= 8'd0;
            fetch_err <= 1'b0;
        end else begin
            tcnt      <= tcnt_n;
            fetch_err <= fetch_err_n;
        end
    end
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: scoreboard of expected fetches plus immediate-assert checks.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_in;
    logic [31:0] pc_next;
    logic        pc_write;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic        flush;
    logic [31:0] flush_target;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;
    logic [63:0] exp_q[$];

    fetch_ctrl dut (
        .clk(clk), .rst(rst), .pc_in(pc_in), .pc_next(pc_next), .pc_write(pc_write),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .inst_valid(inst_valid), .inst_out(inst_out), .inst_pc(inst_pc),
        .inst_ready(inst_ready), .flush(flush), .flush_target(flush_target),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push_fetch(input logic [31:0] addr, input logic [31:0] data);
        exp_q.push_back({addr, data});
    endtask

    task automatic check_fetch(input string tag);
        logic [63:0] e;
        chk({tag, "_valid"}, {31'd0, inst_valid}, 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_pc"}, inst_pc, e[63:32]);
            chk({tag, "_data"}, inst_out, e[31:0]);
        end
    endtask

    initial begin
        rst = 1'b1; pc_in = 32'h0040_0000; mem_ack = 1'b0; mem_rdata = 32'd0;
        inst_ready = 1'b0; flush = 1'b1; flush_target = 32'hDEAD_0000;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_pc_write", {31'd0, pc_write}, 32'd0);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_inst_out", inst_out, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);

        // Release reset with a flush pending: IDLE must ignore it.
        rst = 1'b0;
        #1 chk("idle_flush_pc_write", {31'd0, pc_write}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        chk("first_req", {31'd0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'h0040_0000);
        @(negedge clk);
        chk("req_hold_addr1", mem_addr, 32'h0040_0000);
        @(negedge clk);
        chk("req_hold_addr2", mem_addr, 32'h0040_0000);
        mem_ack = 1'b1; mem_rdata = 32'h8C08_0004;
        push_fetch(32'h0040_0000, 32'h8C08_0004);
        @(negedge clk);
        mem_ack = 1'b0;
        check_fetch("fetch0");
        chk("hold_no_req", {31'd0, mem_req}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("hold_ack_ignored", inst_out, 32'h8C08_0004);
        chk("hold_still_valid", {31'd0, inst_valid}, 32'd1);
        inst_ready = 1'b1;
        #1;
        chk("accept_pc_write", {31'd0, pc_write}, 32'd1);
        chk("accept_pc_next", pc_next, 32'h0040_0004);
        @(negedge clk);
        inst_ready = 1'b0;
        chk("b2b_req", {31'd0, mem_req}, 32'd1);
        chk("b2b_addr", mem_addr, 32'h0040_0004);
        chk("b2b_valid_clr", {31'd0, inst_valid}, 32'd0);

        // Flush in REQ before ack -> DRAIN.
        flush = 1'b1; flush_target = 32'h0040_0100;
        #1;
        chk("req_flush_pc_write", {31'd0, pc_write}, 32'd1);
        chk("req_flush_pc_next", pc_next, 32'h0040_0100);
        @(negedge clk);
        flush = 1'b0;
        chk("drain_req", {31'd0, mem_req}, 32'd1);
        chk("drain_old_addr", mem_addr, 32'h0040_0004);
        @(negedge clk);
        chk("drain_old_addr2", mem_addr, 32'h0040_0004);
        mem_ack = 1'b1; mem_rdata = 32'h1111_1111;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("drain_redirect_addr", mem_addr, 32'h0040_0100);
        chk("drain_dropped", {31'd0, inst_valid}, 32'd0);

        // Flush with ack in the same REQ cycle.
        mem_ack = 1'b1; mem_rdata = 32'h2222_2222; flush = 1'b1; flush_target = 32'h0040_0300;
        #1 chk("req_ack_flush_pc_next", pc_next, 32'h0040_0300);
        @(negedge clk);
        mem_ack = 1'b0; flush = 1'b0;
        chk("req_ack_flush_addr", mem_addr, 32'h0040_0300);
        chk("req_ack_flush_dropped", {31'd0, inst_valid}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h3333_3333;
        push_fetch(32'h0040_0300, 32'h3333_3333);
        @(negedge clk);
        mem_ack = 1'b0;
        check_fetch("fetch1");

        // Flush beats a simultaneous accept in HOLD.
        inst_ready = 1'b1; flush = 1'b1; flush_target = 32'h0040_0200;
        #1;
        chk("hold_flush_pc_write", {31'd0, pc_write}, 32'd1);
        chk("hold_flush_pc_next", pc_next, 32'h0040_0200);
        @(negedge clk);
        inst_ready = 1'b0; flush = 1'b0;
        chk("hold_flush_valid_clr", {31'd0, inst_valid}, 32'd0);
        chk("hold_flush_addr", mem_addr, 32'h0040_0200);

        // Second flush while draining replaces the saved target.
        flush = 1'b1; flush_target = 32'h0040_0400;
        @(negedge clk);
        flush_target = 32'h0040_0500;
        #1;
        chk("drain_flush_pc_write", {31'd0, pc_write}, 32'd1);
        chk("drain_flush_pc_next", pc_next, 32'h0040_0500);
        chk("drain2_old_addr", mem_addr, 32'h0040_0200);
        @(negedge clk);
        flush = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("drain2_addr", mem_addr, 32'h0040_0500);

        // PC wrap at the top of the address space.
        mem_ack = 1'b1; flush = 1'b1; flush_target = 32'hFFFF_FFFC;
        @(negedge clk);
        mem_ack = 1'b0; flush = 1'b0;
        chk("wrap_addr", mem_addr, 32'hFFFF_FFFC);
        mem_ack = 1'b1; mem_rdata = 32'h4444_4444;
        push_fetch(32'hFFFF_FFFC, 32'h4444_4444);
        @(negedge clk);
        mem_ack = 1'b0;
        check_fetch("fetch2");
        inst_ready = 1'b1;
        #1 chk("wrap_pc_next", pc_next, 32'h0000_0000);
        @(negedge clk);
        inst_ready = 1'b0;
        chk("wrap_mem_addr", mem_addr, 32'h0000_0000);
        chk("wrap_mem_req", {31'd0, mem_req}, 32'd1);

        // Reset while a request is outstanding.
        rst = 1'b1; flush = 1'b1;
        #1;
        chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("midrst_pc_write", {31'd0, pc_write}, 32'd0);
        @(negedge clk);
        flush = 1'b0; rst = 1'b0; pc_in = 32'h0000_1000;
        @(negedge clk);
        chk("rerun_req", {31'd0, mem_req}, 32'd1);
        chk("rerun_addr", mem_addr, 32'h0000_1000);
        chk("fetch_err_low", {31'd0, fetch_err}, 32'd0);

`ifdef FETCH_TIMEOUT_EN
        repeat (254) @(negedge clk);
        chk("timeout_254", {31'd0, fetch_err}, 32'd0);
        @(negedge clk);
        chk("timeout_255", {31'd0, fetch_err}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        push_fetch(32'h0000_1000, 32'h5555_5555);
        @(negedge clk);
        mem_ack = 1'b0;
        check_fetch("fetch_late");
        chk("timeout_sticky", {31'd0, fetch_err}, 32'd1);
        rst = 1'b1;
        #1 chk("timeout_rst_clr", {31'd0, fetch_err}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
`else
        repeat (300) @(negedge clk);
        chk("no_timeout_err", {31'd0, fetch_err}, 32'd0);
`endif

        chk("sb_drained", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
